// File: rtl/twostage_otp_decrypt.sv
// twostage_otp_decrypt
//
// Streaming decryptor for the two-stage OTP cipher. The encryptor forms
// C = rev(P ^ K) ^ K, and this block inverts it as P = rev(C ^ K) ^ K. The
// keystream K comes from a local 64-bit Fibonacci LFSR that must stay in step
// with the encryptor, so the LFSR advances once per accepted word and at no
// other time.
//
// Pipeline: stage 1 registers (C ^ K, K). Stage 2 registers
// rev(stage1 data) ^ stage1 key. Both stages use valid/ready handshakes with
// full backpressure.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   cipher_in     ciphertext word
//   cipher_valid  cipher_in is valid
//   cipher_ready  block accepts cipher_in this cycle (combinational)
//   plain_out     recovered plaintext (registered)
//   plain_valid   plain_out is valid
//   plain_ready   consumer accepts plain_out
//   resync        synchronous keystream reload to SEED; also flushes the pipeline
//   words_done    count of delivered plaintext words, wraps at 2^32
//
// Optional build macro DECRYPT_SEED_LOAD_EN adds:
//   seed_load     like resync, but the key is loaded from seed_in
//   seed_in       new keystream seed; zero is replaced by SEED
//
// Only WIDTH = 64 is supported because the LFSR taps are fixed.

module twostage_otp_decrypt #(
    parameter logic [63:0] SEED  = 64'h0000_0000_0000_0001,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cipher_in,
    input  logic             cipher_valid,
    output logic             cipher_ready,
    output logic [WIDTH-1:0] plain_out,
    output logic             plain_valid,
    input  logic             plain_ready,
    input  logic             resync,
    output logic [31:0]      words_done
`ifdef DECRYPT_SEED_LOAD_EN
    ,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in
`endif
);

    logic [WIDTH-1:0] key_q;
    logic [WIDTH-1:0] key_next;
    logic [WIDTH-1:0] s1_data_q;
    logic [WIDTH-1:0] s1_key_q;
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_rev;
    logic [WIDTH-1:0] plain_q;
    logic             plain_valid_q;
    logic [31:0]      words_done_q;

    logic             reload;
    logic [WIDTH-1:0] reload_key;
    logic             s2_load;
    logic             s1_load;
    logic             accept;
    logic             out_hs;

    // Both reload sources flush the pipeline. Only the loaded key differs.
`ifdef DECRYPT_SEED_LOAD_EN
    always_comb begin
        reload     = resync | seed_load;
        reload_key = SEED;
        // seed_load beats resync. A zero seed would lock the LFSR at zero.
        if (seed_load && (seed_in != '0)) begin
            reload_key = seed_in;
        end
    end
`else
    assign reload     = resync;
    assign reload_key = SEED;
`endif

    assign key_next = {key_q[WIDTH-2:0], key_q[63] ^ key_q[62] ^ key_q[60] ^ key_q[59]};

    assign s2_load = !plain_valid_q || plain_ready;
    assign s1_load = !s1_valid_q || s2_load;

    // s1_load expands to !s1_valid || !plain_valid || plain_ready. It must not
    // depend on cipher_valid. A reload cycle ignores the input entirely.
    assign cipher_ready = s1_load && !reload;
    assign accept       = cipher_valid && cipher_ready;
    assign out_hs       = plain_valid_q && plain_ready;

    always_comb begin
        s1_rev = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            s1_rev[i] = s1_data_q[WIDTH-1-i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q         <= SEED;
            s1_data_q     <= '0;
            s1_key_q      <= '0;
            s1_valid_q    <= 1'b0;
            plain_q       <= '0;
            plain_valid_q <= 1'b0;
            words_done_q  <= '0;
        end else if (reload) begin
            // Reload outranks every other event, including a pending output
            // handshake, so words_done does not move in this cycle.
            key_q         <= reload_key;
            s1_valid_q    <= 1'b0;
            plain_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                key_q <= key_next;
            end
            if (out_hs) begin
                words_done_q <= words_done_q + 32'd1;
            end
            if (s2_load) begin
                plain_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    plain_q <= s1_rev ^ s1_key_q;
                end
            end
            if (s1_load) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_data_q <= cipher_in ^ key_q;
                    s1_key_q  <= key_q;
                end
            end
        end
    end

    assign plain_out   = plain_q;
    assign plain_valid = plain_valid_q;
    assign words_done  = words_done_q;

endmodule

// File: tb/tb_twostage_otp_decrypt.sv
// Directed bench for twostage_otp_decrypt. A queue scoreboard holds the
// expected plaintexts in accept order. An independent keystream and encryptor
// model builds each ciphertext.
module tb_twostage_otp_decrypt;

    localparam logic [63:0] SEED = 64'h0000_0000_0000_0001;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ONES_P = 64'h7FFF_FFFF_FFFF_FFFE;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] cipher_in;
    logic        cipher_valid;
    logic        cipher_ready;
    logic [63:0] plain_out;
    logic        plain_valid;
    logic        plain_ready;
    logic        resync;
    logic [31:0] words_done;
    logic        reload_tb;
`ifdef DECRYPT_SEED_LOAD_EN
    logic        seed_load;
    logic [63:0] seed_in;
    assign reload_tb = resync | seed_load;
`else
    assign reload_tb = resync;
`endif

    twostage_otp_decrypt #(.SEED(SEED), .WIDTH(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .cipher_in    (cipher_in),
        .cipher_valid (cipher_valid),
        .cipher_ready (cipher_ready),
        .plain_out    (plain_out),
        .plain_valid  (plain_valid),
        .plain_ready  (plain_ready),
        .resync       (resync),
        .words_done   (words_done)
`ifdef DECRYPT_SEED_LOAD_EN
        ,
        .seed_load    (seed_load),
        .seed_in      (seed_in)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] sb_q[$];
    logic [63:0] mkey;
    logic [31:0] exp_wd;
    int          n_acc = 0;
    int          n_stall = 0;

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[63-i];
        return r;
    endfunction

    function automatic logic [63:0] lfsr_step(input logic [63:0] k);
        return {k[62:0], k[63] ^ k[62] ^ k[60] ^ k[59]};
    endfunction

    function automatic logic [63:0] encrypt(input logic [63:0] p, input logic [63:0] k);
        return rev64(p ^ k) ^ k;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // An output handshake pops the scoreboard at the next edge.
    always @(negedge clk) begin
        if (!rst && !reload_tb && plain_valid && plain_ready) begin
            check("sb_nonempty", {63'd0, sb_q.size() != 0}, 64'd1);
            if (sb_q.size() != 0) begin
                check("plain_out", plain_out, sb_q.pop_front());
            end
            exp_wd = exp_wd + 32'd1;
        end
    end

    // Present one ciphertext until the DUT accepts it. The bench pushes the
    // expected plaintext and steps its model key on that accept.
    task automatic send_raw(input logic [63:0] c, input logic [63:0] p);
        bit done = 1'b0;
        cipher_in    = c;
        cipher_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (cipher_ready) begin
                sb_q.push_back(p);
                mkey = lfsr_step(mkey);
                n_acc++;
                done = 1'b1;
            end else begin
                n_stall++;
            end
            @(posedge clk);
            #1;
        end
        cipher_valid = 1'b0;
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_plain(input logic [63:0] p);
        send_raw(encrypt(p, mkey), p);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int          acc0;
        int          stall0;
        logic [63:0] held;
        bit          have_held;
        bit          saw_valid;

        cipher_in    = '0;
        cipher_valid = 1'b0;
        plain_ready  = 1'b1;
        resync       = 1'b0;
`ifdef DECRYPT_SEED_LOAD_EN
        seed_load    = 1'b0;
        seed_in      = '0;
`endif
        mkey   = SEED;
        exp_wd = '0;
        rst    = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_plain_valid", {63'd0, plain_valid}, 64'd0);
        check("rst_plain_out", plain_out, 64'd0);
        check("rst_words_done", {32'd0, words_done}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cipher_ready", {63'd0, cipher_ready}, 64'd1);
        @(posedge clk);
        #1;

        // A single word shows the two-cycle latency.
        send_raw(ONES, ONES_P);
        @(negedge clk);
        check("lat_not_yet", {63'd0, plain_valid}, 64'd0);
        @(negedge clk);
        check("lat_valid", {63'd0, plain_valid}, 64'd1);
        check("lat_data", plain_out, ONES_P);
        @(posedge clk);
        #1;
        check("words_done_1", {32'd0, words_done}, 64'd1);

        // The second word uses K = 2, so C = 0 decrypts to rev(2) ^ 2.
        send_raw(64'd0, 64'h4000_0000_0000_0002);
        for (int i = 0; i < 62; i++) send_plain({$urandom, $urandom});
        drain();

        // Back-to-back round trip with no stalls.
        stall0 = n_stall;
        for (int i = 0; i < 1000; i++) send_plain({$urandom, $urandom});
        check("b2b_no_stall", 64'(n_stall - stall0), 64'd0);
        drain();
        check("words_done_b2b", {32'd0, words_done}, {32'd0, exp_wd});

        // Backpressure during a burst of 4.
        acc0        = n_acc;
        have_held   = 1'b0;
        held        = '0;
        plain_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send_plain({$urandom, $urandom});
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (plain_valid && have_held) check("stall_stable", plain_out, held);
                    if (plain_valid && !have_held) begin
                        held      = plain_out;
                        have_held = 1'b1;
                    end
                end
                check("stall_ready_low", {63'd0, cipher_ready}, 64'd0);
                check("stall_two_held", 64'(n_acc - acc0), 64'd2);
                @(posedge clk);
                #1 plain_ready = 1'b1;
            end
        join
        drain();
        check("bp_four_steps", 64'(n_acc - acc0), 64'd4);

        // resync with a word in each stage. Input presented that cycle is ignored.
        plain_ready = 1'b0;
        send_plain({$urandom, $urandom});
        send_plain({$urandom, $urandom});
        resync       = 1'b1;
        cipher_valid = 1'b1;
        cipher_in    = {$urandom, $urandom};
        @(negedge clk);
        check("resync_ready_low", {63'd0, cipher_ready}, 64'd0);
        @(posedge clk);
        #1;
        resync       = 1'b0;
        cipher_valid = 1'b0;
        sb_q.delete();
        mkey = SEED;
        @(negedge clk);
        check("resync_valid_clear", {63'd0, plain_valid}, 64'd0);
        check("resync_words_done", {32'd0, words_done}, {32'd0, exp_wd});
        @(posedge clk);
        #1 plain_ready = 1'b1;
        send_raw(ONES, ONES_P);
        drain();

        // Asynchronous reset in the middle of a stall.
        plain_ready = 1'b0;
        send_plain({$urandom, $urandom});
        send_plain({$urandom, $urandom});
        #2 rst = 1'b1;
        #1;
        check("arst_plain_valid", {63'd0, plain_valid}, 64'd0);
        check("arst_plain_out", plain_out, 64'd0);
        check("arst_words_done", {32'd0, words_done}, 64'd0);
        sb_q.delete();
        mkey   = SEED;
        exp_wd = '0;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        plain_ready = 1'b1;
        saw_valid   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (plain_valid) saw_valid = 1'b1;
        end
        check("arst_no_output", {63'd0, saw_valid}, 64'd0);
        @(posedge clk);
        #1;
        send_raw(ONES, ONES_P);
        drain();
        check("arst_words_done_1", {32'd0, words_done}, 64'd1);

`ifdef DECRYPT_SEED_LOAD_EN
        // A zero seed_in falls back to SEED. seed_load beats resync.
        seed_load = 1'b1;
        resync    = 1'b1;
        seed_in   = '0;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        resync    = 1'b0;
        mkey      = SEED;
        send_raw(ONES, ONES_P);
        drain();
        seed_load = 1'b1;
        seed_in   = 64'hDEAD_BEEF_0123_4567;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        mkey      = 64'hDEAD_BEEF_0123_4567;
        for (int i = 0; i < 8; i++) send_plain({$urandom, $urandom});
        drain();
`endif

        check("final_words_done", {32'd0, words_done}, {32'd0, exp_wd});
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
